// File: rtl/mccoy_pkg.sv
// Shared encodings for the McCoy accumulator core: instruction classes,
// per-class sub-ops and the MUL sequencing FSM states.
package mccoy_pkg;

    // Instruction classes (top two instruction bits)
    localparam logic [1:0] CLS_LDN = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_MOV = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    // ALU sub-ops: R0 <= R0 op Rr
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // MOVE/SHIFT sub-ops
    localparam logic [1:0] MOV_TO   = 2'b00;  // Rr <= R0
    localparam logic [1:0] MOV_FROM = 2'b01;  // R0 <= Rr
    localparam logic [1:0] MOV_SHL  = 2'b10;
    localparam logic [1:0] MOV_SHR  = 2'b11;

    // SYS sub-ops
    localparam logic [1:0] SYS_MUL = 2'b00;
    localparam logic [1:0] SYS_OUT = 2'b01;
    localparam logic [1:0] SYS_NOP = 2'b10;
    localparam logic [1:0] SYS_CLR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mccoy_mul_seq.sv
// Shift-add multiplier: operands load on start, then one partial product is
// folded in per clock for DATA_W clocks. done/product are combinational in the
// final iteration cycle so the caller can capture the result on that same edge.
module mccoy_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    import mccoy_pkg::*;

    localparam int CW = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc_nxt;

    // Accumulator value after the current iteration
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end

    assign product = acc_nxt;
    assign done    = busy && (cnt == CW'(1));

    // Operand load on start, then one shift-add step per clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(DATA_W);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mccoy_core_p.sv
// Parametrised McCoy accumulator core: decodes one instruction per accepted
// beat, holds the register file, carry flag and output latch, and sequences
// the multi-cycle multiply through a two-state FSM.
module mccoy_core_p #(
    parameter int DATA_W  = 8,
    parameter int NREG    = 4,
    localparam int RW      = $clog2(NREG),
    localparam int INSTR_W = 4 + RW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               ready,
    output logic [DATA_W-1:0]  data_out,
    output logic               carry,
    output logic               out_strobe
);
    import mccoy_pkg::*;

    logic [NREG-1:0][DATA_W-1:0] regs;

    logic [1:0]    cls;
    logic [1:0]    sub;
    logic [RW-1:0] r;
    logic [3:0]    imm;

    assign cls = instr[INSTR_W-1:INSTR_W-2];
    assign sub = instr[INSTR_W-3:INSTR_W-4];
    assign r   = instr[RW-1:0];
    assign imm = instr[3:0];

    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] rr;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;

    assign r0   = regs[0];
    assign rr   = regs[r];
    assign sum  = {1'b0, r0} + {1'b0, rr};
    assign diff = r0 - rr;

    state_t state;
    state_t state_nxt;

    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic                accept;

    assign accept = instr_valid && ready;

    // Operands are snapshotted inside the sequencer on the accepting edge;
    // with r=0 both come from R0, giving R0 squared.
    mccoy_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (r0),
        .b       (rr),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: leave IDLE on an accepted MUL, return on the last step
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle; kick the multiplier on MUL accept
    always_comb begin
        ready     = (state == ST_IDLE) && !mul_busy;
        mul_start = (state == ST_IDLE) && !mul_busy && instr_valid &&
                    (cls == CLS_SYS) && (sub == SYS_MUL);
    end

    // Register file, carry and output latch; MUL write-back cannot collide
    // with a decoded instruction because nothing is accepted while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs       <= '0;
            carry      <= 1'b0;
            data_out   <= '0;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= 1'b0;
            if (mul_done) begin
                regs[0] <= mul_product[DATA_W-1:0];
                carry   <= |mul_product[2*DATA_W-1:DATA_W];
            end else if (accept) begin
                case (cls)
                    CLS_LDN: regs[0] <= {r0[DATA_W-5:0], imm};
                    CLS_ALU: begin
                        case (sub)
                            ALU_ADD: begin
                                regs[0] <= sum[DATA_W-1:0];
                                carry   <= sum[DATA_W];
                            end
                            ALU_SUB: begin
                                regs[0] <= diff;
                                carry   <= (r0 < rr);
                            end
                            ALU_AND: begin
                                regs[0] <= r0 & rr;
                                carry   <= 1'b0;
                            end
                            default: begin
                                regs[0] <= r0 ^ rr;
                                carry   <= 1'b0;
                            end
                        endcase
                    end
                    CLS_MOV: begin
                        case (sub)
                            MOV_TO:   regs[r] <= r0;
                            MOV_FROM: regs[0] <= rr;
                            MOV_SHL: begin
                                carry   <= r0[DATA_W-1];
                                regs[0] <= r0 << 1;
                            end
                            default: begin
                                carry   <= r0[0];
                                regs[0] <= r0 >> 1;
                            end
                        endcase
                    end
                    default: begin
                        case (sub)
                            SYS_OUT: begin
                                data_out   <= rr;
                                out_strobe <= 1'b1;
                            end
                            SYS_CLR: begin
                                regs  <= '0;
                                carry <= 1'b0;
                            end
                            default: ;  // NOP; MUL handled by the sequencer
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mccoy_core_p.sv
// Bench for mccoy_core_p: an 8-bit/4-reg instance and a 16-bit/8-reg instance.
// OUT instructions push the expected {data_out, carry} into a per-instance
// queue; a negedge monitor pops and compares on every out_strobe.
module tb_mccoy_core_p;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [5:0]  instr0 = '0;
    logic        v0 = 1'b0;
    logic        rdy0, c0, s0;
    logic [7:0]  d0;

    logic [6:0]  instr1 = '0;
    logic        v1 = 1'b0;
    logic        rdy1, c1, s1;
    logic [15:0] d1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] data;
        logic        c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic ps0 = 1'b0, ps1 = 1'b0;

    always #5 clk = ~clk;

    mccoy_core_p #(.DATA_W(8), .NREG(4)) u0 (
        .clk(clk), .reset(reset), .instr(instr0), .instr_valid(v0),
        .ready(rdy0), .data_out(d0), .carry(c0), .out_strobe(s0)
    );

    mccoy_core_p #(.DATA_W(16), .NREG(8)) u1 (
        .clk(clk), .reset(reset), .instr(instr1), .instr_valid(v1),
        .ready(rdy1), .data_out(d1), .carry(c1), .out_strobe(s1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!reset && s0) begin
            chk("strobe0_width", 16'(ps0), 16'd0);
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe0_unexpected: got data %0h with no pending OUT", d0);
            end else begin
                e0 = q0.pop_front();
                chk("data_out0", 16'(d0), e0.data);
                chk("carry0", 16'(c0), 16'(e0.c));
            end
        end
        ps0 = s0;
    end

    always @(negedge clk) begin
        if (!reset && s1) begin
            chk("strobe1_width", 16'(ps1), 16'd0);
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe1_unexpected: got data %0h with no pending OUT", d1);
            end else begin
                e1 = q1.pop_front();
                chk("data_out1", d1, e1.data);
                chk("carry1", 16'(c1), 16'(e1.c));
            end
        end
        ps1 = s1;
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [7:0] op(input int d, input logic [1:0] cls,
                                      input logic [1:0] sub, input logic [2:0] r);
        return (d == 0) ? {2'b00, cls, sub, r[1:0]} : {1'b0, cls, sub, r};
    endfunction

    // Present one instruction, waiting (bounded) for ready
    task automatic send(input int d, input logic [7:0] w);
        int n = 0;
        while (rdy(d) !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL ready_timeout: dut%0d ready never rose", d);
        end
        if (d == 0) begin instr0 = w[5:0]; v0 = 1'b1; end
        else        begin instr1 = w[6:0]; v1 = 1'b1; end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic ldn(input int d, input logic [3:0] imm);
        send(d, {4'b0000, imm});
    endtask

    task automatic ex(input int d, input logic [1:0] cls, input logic [1:0] sub, input logic [2:0] r);
        send(d, op(d, cls, sub, r));
    endtask

    task automatic out(input int d, input logic [2:0] r, input logic [15:0] data, input logic c);
        exp_t e;
        e.data = data;
        e.c    = c;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        ex(d, 2'b11, 2'b01, r);
    endtask

    // Issue MUL, hammer LDN 0xF while busy, and count busy cycles
    task automatic mul(input int d, input logic [2:0] r, input int expw);
        int n = 0;
        ex(d, 2'b11, 2'b00, r);
        while (rdy(d) == 1'b0 && n < 100) begin
            if (d == 0) begin instr0 = 6'b00_1111; v0 = 1'b1; end
            else        begin instr1 = 7'b000_1111; v1 = 1'b1; end
            @(posedge clk); #1; n++;
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("mul_busy_cycles", 16'(n), 16'(expw));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 16'(rdy0), 16'd1);
        chk("rst_data0", 16'(d0), 16'd0);
        chk("rst_carry0", 16'(c0), 16'd0);
        chk("rst_strobe0", 16'(s0), 16'd0);
        chk("rst_ready1", 16'(rdy1), 16'd1);
        chk("rst_data1", d1, 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LDN / OUT
        ldn(0, 4'hA); ldn(0, 4'h5);
        out(0, 0, 16'hA5, 1'b0);

        // ALU: ADD overflow, SUB borrow, AND, XOR, MOV from
        ldn(0, 4'hF); ldn(0, 4'h0);           // R0=F0
        ex(0, 2'b10, 2'b00, 3'd1);            // R1=F0
        ldn(0, 4'h2); ldn(0, 4'h0);           // R0=20
        ex(0, 2'b01, 2'b00, 3'd1);            // ADD -> 10, c=1
        out(0, 0, 16'h10, 1'b1);
        ex(0, 2'b01, 2'b01, 3'd1);            // SUB -> 20, c=1
        out(0, 0, 16'h20, 1'b1);
        ex(0, 2'b01, 2'b10, 3'd1);            // AND -> 20, c=0
        out(0, 0, 16'h20, 1'b0);
        ex(0, 2'b01, 2'b11, 3'd1);            // XOR -> D0, c=0
        out(0, 0, 16'hD0, 1'b0);
        ex(0, 2'b10, 2'b01, 3'd1);            // R0=R1=F0
        out(0, 0, 16'hF0, 1'b0);

        // MUL 0x0D * 0x0B = 0x8F, then 0xFF squared
        ldn(0, 4'h0); ldn(0, 4'hB);
        ex(0, 2'b10, 2'b00, 3'd1);            // R1=0B
        ldn(0, 4'h0); ldn(0, 4'hD);
        mul(0, 3'd1, 8);
        out(0, 0, 16'h8F, 1'b0);
        ldn(0, 4'hF); ldn(0, 4'hF);
        mul(0, 3'd0, 8);
        out(0, 0, 16'h01, 1'b1);

        // Reset three cycles into a MUL
        ldn(0, 4'h3); ldn(0, 4'h3);
        ex(0, 2'b11, 2'b00, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midmul_ready0", 16'(rdy0), 16'd1);
        chk("midmul_data0", 16'(d0), 16'd0);
        chk("midmul_carry0", 16'(c0), 16'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        out(0, 0, 16'h00, 1'b0);

        // Shifts and CLR
        ldn(0, 4'h8); ldn(0, 4'h1);           // R0=81
        ex(0, 2'b10, 2'b10, 3'd0);            // SHL -> 02, c=1
        out(0, 0, 16'h02, 1'b1);
        ex(0, 2'b10, 2'b11, 3'd0);            // SHR -> 01, c=0
        out(0, 0, 16'h01, 1'b0);
        ex(0, 2'b10, 2'b00, 3'd1);            // R1=01
        ldn(0, 4'h8); ldn(0, 4'h0);           // R0=80
        ex(0, 2'b10, 2'b10, 3'd0);            // SHL -> 00, c=1
        chk("shl_carry0", 16'(c0), 16'd1);
        ex(0, 2'b11, 2'b11, 3'd0);            // CLR
        chk("clr_carry0", 16'(c0), 16'd0);
        chk("clr_keeps_data0", 16'(d0), 16'h01);
        out(0, 1, 16'h00, 1'b0);
        ex(0, 2'b11, 2'b10, 3'd0);            // NOP
        out(0, 0, 16'h00, 1'b0);

        // Wide instance: DATA_W=16, NREG=8
        ldn(1, 4'h0); ldn(1, 4'h0); ldn(1, 4'h0); ldn(1, 4'h2);
        ex(1, 2'b10, 2'b00, 3'd7);            // R7=0002
        ldn(1, 4'h1); ldn(1, 4'h2); ldn(1, 4'h3); ldn(1, 4'h4);
        mul(1, 3'd7, 16);
        out(1, 0, 16'h2468, 1'b0);
        ex(1, 2'b01, 2'b00, 3'd7);            // ADD -> 246A
        out(1, 0, 16'h246A, 1'b0);
        ex(1, 2'b10, 2'b11, 3'd0);            // SHR -> 1235, c=0
        out(1, 0, 16'h1235, 1'b0);
        ex(1, 2'b11, 2'b10, 3'd0);            // NOP
        out(1, 7, 16'h0002, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 16'(q0.size()), 16'd0);
        chk("q1_drained", 16'(q1.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
